// File: rtl/uart_rx_frame_capture.sv
// 16x-oversampled UART receiver with runtime framing config, show-ahead capture
// FIFO (valid/ready drain) and saturating frame/error counters.
module uart_rx_frame_capture #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_baud_div,
  input  logic [3:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             rx_i,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [8:0]       m_data,
  output logic             m_par_err,
  output logic             m_frm_err,
  output logic             m_break,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_status,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;

  logic             sync1, sync2, rx_d, fall;
  logic [DIV_W-1:0] baud_l, div_cnt;
  logic [3:0]       nbits_l, phase, bit_idx;
  logic [1:0]       par_l;
  logic             stop2_l, stop_idx;
  logic             s7, s8, vote, tick, vote_ev, start_det, par_en, frame_done;
  logic [8:0]       data_r;
  logic             par_err_r, frm_err_r, brk_r;
  logic             push_req;
  logic [11:0]      push_entry, head;
  logic [11:0]      mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, push_ok;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      sync2 <= sync1;
      rx_d  <= sync2;
    end
  end

  assign fall      = rx_d & ~sync2;
  assign busy      = (state != IDLE);
  assign start_det = (state == IDLE) && cfg_en && fall;
  assign tick      = busy && (div_cnt == baud_l);
  assign vote_ev   = tick && (phase == 4'd9);
  assign vote      = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
  assign par_en    = (par_l == 2'd1) || (par_l == 2'd2);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE:   if (start_det) state_nxt = START;
      START:  if (vote_ev) state_nxt = vote ? IDLE : DATA;
      DATA:   if (vote_ev && (bit_idx == nbits_l - 4'd1)) state_nxt = par_en ? PARITY : STOP;
      PARITY: if (vote_ev) state_nxt = STOP;
      STOP: begin
        if (vote_ev && (!stop2_l || stop_idx)) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Disabling mid-frame aborts, overriding any frame completion on the same cycle.
    if (busy && !cfg_en) begin
      state_nxt  = IDLE;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      baud_l    <= '0;
      nbits_l   <= 4'd8;
      par_l     <= '0;
      stop2_l   <= 1'b0;
      div_cnt   <= '0;
      phase     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      data_r    <= '0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      brk_r     <= 1'b0;
    end else if (start_det) begin
      baud_l    <= cfg_baud_div;
      nbits_l   <= (cfg_data_bits >= 4'd5 && cfg_data_bits <= 4'd9) ? cfg_data_bits : 4'd8;
      par_l     <= cfg_parity;
      stop2_l   <= cfg_stop2;
      div_cnt   <= '0;
      phase     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      data_r    <= '0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      brk_r     <= 1'b0;
    end else if (busy) begin
      if (tick) begin
        div_cnt <= '0;
        phase   <= phase + 4'd1;
        if (phase == 4'd7) s7 <= sync2;
        if (phase == 4'd8) s8 <= sync2;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (vote_ev) begin
        unique case (state)
          DATA: begin
            data_r[bit_idx] <= vote;
            bit_idx         <= bit_idx + 4'd1;
          end
          PARITY: par_err_r <= ((^data_r) ^ vote) != (par_l == 2'd1);
          STOP: begin
            if (!stop_idx) brk_r <= (data_r == '0) && !vote;
            frm_err_r <= frm_err_r | ~vote;
            stop_idx  <= 1'b1;
          end
          default: ;
        endcase
      end
    end else begin
      div_cnt <= '0;
    end
  end

  // The final stop vote is folded in here since its register update lands too late.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      push_req   <= 1'b0;
      push_entry <= '0;
    end else begin
      push_req <= frame_done;
      if (frame_done)
        push_entry <= {stop_idx ? brk_r : ((data_r == '0) && !vote),
                       frm_err_r | ~vote, par_err_r, data_r};
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && m_ready;
  assign push_ok = push_req && (!full || pop);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign m_valid = !empty;
  assign {m_break, m_frm_err, m_par_err, m_data} = m_valid ? head : '0;

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (clr_status) begin
        overflow  <= 1'b0;
        frame_cnt <= '0;
        err_cnt   <= '0;
      end else if (push_req) begin
        if (full && !pop)        overflow  <= 1'b1;
        if (frame_cnt != '1)     frame_cnt <= frame_cnt + CNT_W'(1);
        if ((|push_entry[11:9]) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/uart_rx_frame_capture.md
Name: uart_rx_frame_capture

Overview:
Synthesizable, runtime-configurable UART receiver that replaces fixed-timing behavioural TX-pad monitoring with an on-chip or bench-reusable capture block. It oversamples the serial line at 16x with majority voting. It supports 5-9 data bits, optional odd/even parity and 1 or 2 stop bits. Frames are pushed with error flags into a show-ahead FIFO that is drained by a valid/ready handshake; frame and error counters run alongside.

Parameters:
DIV_W, 16, width of the oversample divisor
FIFO_DEPTH, 8, entries in the capture FIFO (power of 2, at least 2)
CNT_W, 16, width of the frame and error counters

Ports:
sys_clk  in  1  single clock for all logic
sys_rst  in  1  synchronous, active-high reset
cfg_en  in  1  receiver enable; 0 forces IDLE with no start detection
cfg_baud_div  in  DIV_W  sys_clk cycles per oversample tick, minus 1
cfg_data_bits  in  4  data bits per frame, 5..9; any other value is treated as 8
cfg_parity  in  2  0 = none, 1 = odd, 2 = even, 3 = none
cfg_stop2  in  1  1 = two stop bits checked
rx_i  in  1  asynchronous serial input, idle high
m_valid  out  1  FIFO head entry available
m_ready  in  1  consumer accepts the head entry
m_data  out  9  received data, LSB-aligned, unused upper bits 0
m_par_err  out  1  head entry parity error
m_frm_err  out  1  head entry stop-bit error
m_break  out  1  head entry is a break (all data 0 and first stop 0)
busy  out  1  state is not IDLE
overflow  out  1  sticky: a frame was dropped because the FIFO was full
clr_status  in  1  clears overflow, frame_cnt and err_cnt
frame_cnt  out  CNT_W  saturating count of completed frames, including errored frames
err_cnt  out  CNT_W  saturating count of frames with par, frm or break set

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, tick counter 0, synchroniser flops 1.
- Input conditioning: rx_i passes through a 2-flop synchroniser, then a 1-flop edge register.
- Tick generation: a counter runs 0..cfg_baud_div and pulses tick on terminal count. It runs only while busy and restarts at 0 on start detect. Each bit spans 16 ticks; the sample phase is 0..15.
- Sampling: each bit value is the majority of samples at phases 7, 8 and 9.
- Config latching: all cfg_* fields are latched at start detect. Mid-frame cfg changes take effect on the next frame.
- IDLE: a synced falling edge with cfg_en=1 moves to START.
- START: at the phase-9 vote, 1 is a false start and returns to IDLE with no push and no count change; 0 moves to DATA.
- DATA: shifts LSB-first for the latched number of bits, then goes to PARITY if parity is enabled, otherwise to STOP.
- PARITY: odd or even check over the data bits.
- STOP: checks 1 or 2 stop bits; a 0 on any stop bit sets frm_err.
- Break: set when all data bits are 0 and the first stop bit is 0.
- Frame end: after the last stop vote (phase 9) the block returns to IDLE immediately. A falling edge on the very next cycle is accepted, so back-to-back frames with a short stop bit are captured.
- FIFO push: {break, frm, par, data} is pushed on the cycle after the last stop vote. m_valid rises the following cycle, giving 2 sys_clk cycles from the final vote to m_valid.
- FIFO full at push: the entry is dropped and overflow is set. The frame is still counted in frame_cnt, and in err_cnt if it carried an error.
- FIFO is show-ahead: m_valid = !empty and the head fields are stable while m_valid=1 and m_ready=0. A pop occurs when m_valid and m_ready are both 1.
- Simultaneous push and pop when full: the pop is honoured and the push is accepted with no overflow. When empty, a push is not visible until the next cycle.
- Counters: frame_cnt and err_cnt saturate at all-ones. If clr_status coincides with an increment, clear wins.
- cfg_en deasserted mid-frame: the frame is aborted, the state returns to IDLE, and there is no push or count. FIFO contents are kept.
- sys_rst mid-frame: full reset, FIFO is flushed.

Test Plan:
- 100 MHz sys_clk, cfg_baud_div=53 (864-cycle bit, 8640 ns, 115200 baud), 8N1. Send 0x01, 0x02, 0x03, 0x04 back-to-back with m_ready=1 -> four entries in order, all flags 0, frame_cnt=4, err_cnt=0.
- 7E1 (cfg_data_bits=7, cfg_parity=2). Send 0x55 with a wrong parity bit -> m_data=0x055, m_par_err=1, err_cnt=1. A correct 0x2A follows -> no error flags.
- 8N2 with the second stop bit driven 0 -> m_frm_err=1. Hold the line low for 12 bit times, then release -> one entry with m_data=0, m_break=1, m_frm_err=1.
- 300 ns low glitch on an idle line -> no entry, frame_cnt unchanged, busy returns to 0 within 1 bit time.
- m_ready=0, send 9 frames 0x10..0x18 -> 8 entries held, overflow=1, frame_cnt=9. Drain yields 0x10..0x17. Pulse clr_status -> overflow=0, frame_cnt=0.
- Assert sys_rst during data bit 3 of 0xA5 -> all outputs 0 on the next cycle. A following 0xC3 is captured correctly.
